prime_user_ctrl: RTL and testbench
==================================

# prime_user_ctrl

User-facing front end that drives the `prime` checker. Conditions three raw push-buttons, maintains a 4-bit operand selected by increment/decrement, and on start issues a one-cycle request to the checker. It then tracks the checker's `valid` handshake and latches the verdict for display. It sits directly upstream of `prime`: it feeds that block's `en_i`/`data_i` and consumes its `valid_o`/`prime_o`.

## Interface
- `DEBOUNCE_CYCLES`, default 16: number of consecutive stable synchronized samples required before a button level is accepted.
- `TIMEOUT_CYCLES`, default 64: maximum number of cycles spent waiting on the checker before the request is aborted.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `inc_i` input 1: raw increment button, active-high, asynchronous to `clk`.
- `dec_i` input 1: raw decrement button, active-high, asynchronous to `clk`.
- `start_i` input 1: raw start button, active-high, asynchronous to `clk`.
- `valid_i` input 1: checker `valid_o`. High means idle or result ready.
- `prime_i` input 1: checker `prime_o`. Meaningful only when `valid_i` is high after a completed request.
- `en_o` output 1: one-cycle request pulse to the checker `en_i`.
- `data_o` output 4: operand to the checker `data_i`. Held stable while busy.
- `leds_o` output 4: operand display. Always equals `data_o`.
- `prime_led_o` output 1: latched verdict of the last completed check.
- `busy_o` output 1: high from the request until the verdict is latched or the request is aborted.
- `err_o` output 1: sticky timeout flag. Cleared by the next accepted start.

## Operation
- **Button path**, per button:
  - 2-flop synchronizer.
  - Optional debounce (see Configuration).
  - Rising-edge detector producing a one-cycle pulse: `inc_p`, `dec_p`, `start_p`.
- **Operand register** `op[3:0]`, reset value 0:
  - `inc_p` alone: `op+1`; 15 wraps to 0.
  - `dec_p` alone: `op-1`; 0 wraps to 15.
  - `inc_p` and `dec_p` in the same cycle: no change.
  - Pulses are ignored while `busy_o` is high.
- **FSM states**: IDLE, REQ, WAIT_LO, WAIT_HI, SHOW.
  - IDLE, on `start_p`: clear `err_o`.
    - If `op` < 2: go to SHOW with verdict 0. The checker is not invoked, because it does not terminate for 1.
    - Otherwise: go to REQ.
  - REQ: `en_o`=1 for exactly this cycle, then go to WAIT_LO.
  - WAIT_LO: wait for `valid_i`=0 (checker entered compute), then go to WAIT_HI.
  - WAIT_HI: wait for `valid_i`=1, then latch `prime_i` into `prime_led_o` and go to SHOW.
  - SHOW: one cycle, then go to IDLE.
- **Timeout**: a counter starts at 0 on entry to WAIT_LO and increments in both WAIT_LO and WAIT_HI. On reaching `TIMEOUT_CYCLES`-1 with the awaited condition unmet:
  - set `err_o`;
  - leave `prime_led_o` unchanged;
  - go to IDLE.
- **Busy flag**: `busy_o` is high in REQ, WAIT_LO and WAIT_HI, and for the one-cycle short-path SHOW.
- **Start handling**: `start_p` is ignored while not in IDLE. An inc/dec pulse in the same cycle as an accepted start is applied first, so the request uses the updated `op`.
- **Reset mid-operation**: all state returns to reset values immediately. The checker shares `rst_n`, so no handshake is left hanging.

## Timing
- **Reset values**: `en_o`=0, `data_o`=0, `leds_o`=0, `prime_led_o`=0, `busy_o`=0, `err_o`=0. FSM resets to IDLE.
- **Button latency**: raw edge to pulse is 3 cycles without debounce, or 3+`DEBOUNCE_CYCLES` cycles with debounce.
- **Start to request**: `start_p` in cycle T gives `en_o` high in T+1 (REQ), with `busy_o` high from T+1.
- **Checker handshake**: `valid_i` falls at T+3. WAIT_HI exits one cycle after `valid_i` rises. `prime_led_o` updates on that same edge, and `busy_o` drops one cycle later.
- **Outputs**: all outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `PRIME_DEBOUNCE_EN` defined: each button passes through a saturating counter of width $clog2(`DEBOUNCE_CYCLES`+1). The accepted level changes only after `DEBOUNCE_CYCLES` equal consecutive samples.
- `PRIME_DEBOUNCE_EN` undefined: the synchronizer output feeds the edge detector directly. `DEBOUNCE_CYCLES` is unused.

## Structure
- **Shared package `prime_pkg`** holds:
  - FSM state enum `ctrl_state_t` (one-hot, 5 bits);
  - operand width constant `OP_W`=4;
  - constant `MIN_CANDIDATE`=2.
- **Sub-module `btn_cond`**: synchronizer, conditional debounce and rising-edge pulse. Instantiated three times.

## Test plan
- **Wrap-around**: after reset, 1 inc pulse → `leds_o`=1. Then 2 dec pulses → `leds_o`=15. Then 1 inc → 0.
- **Prime operand**: `op`=7, start, with the real `prime` instance attached → `en_o` is a single-cycle pulse; `data_o` stays 7 while busy; `prime_led_o`=1; `busy_o` falls.
- **Non-prime operand**: `op`=9, start → `prime_led_o`=0. Then `op`=2, start → `prime_led_o`=1.
- **Short path**: `op`=1, start → `en_o` never asserts; `prime_led_o`=0; `busy_o` high for exactly 1 cycle.
- **Ignored inputs while busy**: during busy, pulse inc and start → `op` unchanged; no second `en_o`. Also press inc and dec simultaneously while idle → `op` unchanged.
- **Timeout and reset**: tie `valid_i`=1, start with `op`=5 → after `TIMEOUT_CYCLES` `err_o`=1 and `prime_led_o` is unchanged. Separately, assert `rst_n`=0 during WAIT_HI → all outputs read 0.

Source files
------------

// File: rtl/prime_user_ctrl_pkg.sv
// Shared definitions for the prime checker front end (package prime_pkg).
package prime_pkg;

  localparam int unsigned OP_W          = 4;
  localparam int unsigned MIN_CANDIDATE = 2;

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_REQ     = 5'b00010,
    S_WAIT_LO = 5'b00100,
    S_WAIT_HI = 5'b01000,
    S_SHOW    = 5'b10000
  } ctrl_state_t;

endpackage

// File: rtl/prime_user_ctrl_if.sv
// Request/verdict handshake between the user front end and the prime checker.
interface prime_user_ctrl_if;
  import prime_pkg::*;

  logic            en_o;
  logic [OP_W-1:0] data_o;
  logic            valid_i;
  logic            prime_i;

  modport master (output en_o, output data_o, input valid_i, input prime_i);
  modport slave  (input en_o, input data_o, output valid_i, output prime_i);
endinterface

// File: rtl/prime_user_ctrl_btn_cond.sv
// Button conditioner: 2-flop synchronizer, optional debounce (PRIME_DEBOUNCE_EN),
// registered rising-edge pulse.
module btn_cond
`ifdef PRIME_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic [1:0] sync_q;
  logic       lvl;
  logic       lvl_d_q;

  // Bring the raw button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], btn_i};
  end

`ifdef PRIME_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic          stable_q;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else if (sync_q[1] == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= sync_q[1];
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lvl = stable_q;
`else
  assign lvl = sync_q[1];
`endif

  // One-cycle pulse on each accepted rising level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvl_d_q <= 1'b0;
      pulse_o <= 1'b0;
    end else begin
      lvl_d_q <= lvl;
      pulse_o <= lvl & ~lvl_d_q;
    end
  end

endmodule

// File: rtl/prime_user_ctrl.sv
// User front end for the prime checker: button conditioning, operand register,
// request FSM with timeout, latched verdict. Optional macro: PRIME_DEBOUNCE_EN.
module prime_user_ctrl
  import prime_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            dec_i,
  input  logic            start_i,
  prime_user_ctrl_if.master chk,
  output logic [OP_W-1:0] leds_o,
  output logic            prime_led_o,
  output logic            busy_o,
  output logic            err_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Degenerate lengths elaborate an empty marker scope that is easy to spot in the hierarchy.
  if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES < 2) begin : g_param_out_of_range
  end

  logic [2:0] btn_raw;
  logic [2:0] btn_p;
  logic       inc_p, dec_p, start_p;

  assign btn_raw = {start_i, dec_i, inc_i};
  assign inc_p   = btn_p[0];
  assign dec_p   = btn_p[1];
  assign start_p = btn_p[2];

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_cond
`ifdef PRIME_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (btn_raw[b]),
        .pulse_o (btn_p[b])
      );
  end

  ctrl_state_t     state_q, state_n;
  logic [OP_W-1:0] op_q, op_n;
  logic [TO_W-1:0] cnt_q, cnt_n;
  logic            led_q, led_n;
  logic            err_q, err_n;
  logic            busy_q, en_q;

  // Operand update; a start in the same cycle sees the updated value through op_n.
  always_comb begin
    op_n = op_q;
    if (!busy_q && inc_p && !dec_p)      op_n = op_q + 1'b1;
    else if (!busy_q && dec_p && !inc_p) op_n = op_q - 1'b1;
  end

  // Request sequencing, wait-cycle counting and verdict capture.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    led_n   = led_q;
    err_n   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_p) begin
          err_n = 1'b0;
          if (op_n < OP_W'(MIN_CANDIDATE)) begin
            led_n   = 1'b0;
            state_n = S_SHOW;
          end else begin
            state_n = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_n   = '0;
        state_n = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!chk.valid_i) begin
          cnt_n   = cnt_q + 1'b1;
          state_n = S_WAIT_HI;
        end else if (cnt_q == TO_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_WAIT_HI: begin
        if (chk.valid_i) begin
          led_n   = chk.prime_i;
          state_n = S_SHOW;
        end else if (cnt_q == TO_LAST) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      S_SHOW:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; en/busy are decoded from the next state so they are flop outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      op_q    <= op_n;
      cnt_q   <= cnt_n;
      led_q   <= led_n;
      err_q   <= err_n;
      busy_q  <= (state_n != S_IDLE);
      en_q    <= (state_n == S_REQ);
    end
  end

  assign chk.en_o    = en_q;
  assign chk.data_o  = op_q;
  assign leds_o      = op_q;
  assign prime_led_o = led_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_prime_user_ctrl.sv
// Self-checking bench for prime_user_ctrl (default build, no debounce).
module tb_prime_user_ctrl;
  import prime_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       inc_raw = 1'b0, dec_raw = 1'b0, start_raw = 1'b0;
  logic [3:0] leds;
  logic       prime_led, busy, err;

  prime_user_ctrl_if chk_if ();

  prime_user_ctrl #(.DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(64)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_i       (inc_raw),
    .dec_i       (dec_raw),
    .start_i     (start_raw),
    .chk         (chk_if),
    .leds_o      (leds),
    .prime_led_o (prime_led),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int unsigned exp_op = 0;
  logic        exp_led = 1'b0;
  int unsigned chk_lat = 4;
  logic        chk_stuck = 1'b0;
  int          en_total = 0;

  function automatic logic is_prime(input int unsigned n);
    if (n < 2) return 1'b0;
    for (int unsigned d = 2; d * d <= n; d++) if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural checker: takes a request, drops valid, answers after chk_lat cycles.
  logic        chk_active;
  int unsigned chk_left;
  logic [3:0]  chk_operand;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_if.valid_i <= 1'b1; chk_if.prime_i <= 1'b0;
      chk_active <= 1'b0; chk_left <= 0; chk_operand <= '0;
    end else if (!chk_active) begin
      if (chk_if.en_o && !chk_stuck) begin
        chk_active <= 1'b1; chk_operand <= chk_if.data_o;
        chk_left <= chk_lat; chk_if.valid_i <= 1'b0;
      end
    end else if (chk_left == 0) begin
      chk_if.valid_i <= 1'b1; chk_if.prime_i <= is_prime(chk_operand); chk_active <= 1'b0;
    end else begin
      chk_left <= chk_left - 1;
    end
  end

  always @(negedge clk) if (rst_n && chk_if.en_o) en_total++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
    $fatal(1);
  end

  task automatic press(input logic i, input logic d);
    @(negedge clk); inc_raw = i; dec_raw = d;
    @(negedge clk); inc_raw = 1'b0; dec_raw = 1'b0;
    repeat (4) @(negedge clk);
    if (i && !d) exp_op = (exp_op + 1) % 16;
    else if (d && !i) exp_op = (exp_op + 15) % 16;
  endtask

  task automatic set_op(input int unsigned target);
    while (exp_op != target) press(1'b1, 1'b0);
  endtask

  task automatic do_start(input logic with_inc, output int bcyc, output int ecnt,
                          output logic data_ok, output logic tout);
    int n;
    bcyc = 0; ecnt = 0; data_ok = 1'b1; tout = 1'b0; n = 0;
    @(negedge clk); start_raw = 1'b1; inc_raw = with_inc;
    @(negedge clk); start_raw = 1'b0; inc_raw = 1'b0;
    if (with_inc) exp_op = (exp_op + 1) % 16;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    if (!busy) tout = 1'b1;
    n = 0;
    while (busy && n < 300) begin
      if (chk_if.en_o) ecnt++;
      if (chk_if.data_o !== 4'(exp_op)) data_ok = 1'b0;
      bcyc++; n++;
      @(negedge clk);
    end
    if (busy) tout = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (chk_if.en_o !== 1'b0) begin miscompares++; $display("FAIL reset_en: got %b expected 0", chk_if.en_o); end
    vectors++; if (chk_if.data_o !== 4'd0) begin miscompares++; $display("FAIL reset_data: got %0d expected 0", chk_if.data_o); end
    vectors++; if (leds !== 4'd0) begin miscompares++; $display("FAIL reset_leds: got %0d expected 0", leds); end
    vectors++; if (prime_led !== 1'b0) begin miscompares++; $display("FAIL reset_prime_led: got %b expected 0", prime_led); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_wrap;
    // Raw edge -> pulse takes 3 edges, operand register one more.
    @(negedge clk); inc_raw = 1'b1;
    @(negedge clk); inc_raw = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++; if (leds !== 4'd0) begin miscompares++; $display("FAIL latency_early: got %0d expected 0", leds); end
    @(negedge clk);
    vectors++; if (leds !== 4'd1) begin miscompares++; $display("FAIL wrap_inc1: got %0d expected 1", leds); end
    exp_op = 1;
    repeat (2) @(negedge clk);
    press(1'b0, 1'b1);
    vectors++; if (leds !== 4'd0) begin miscompares++; $display("FAIL wrap_dec1: got %0d expected 0", leds); end
    press(1'b0, 1'b1);
    vectors++; if (leds !== 4'd15) begin miscompares++; $display("FAIL wrap_dec2: got %0d expected 15", leds); end
    press(1'b1, 1'b0);
    vectors++; if (leds !== 4'd0) begin miscompares++; $display("FAIL wrap_inc2: got %0d expected 0", leds); end
  endtask

  task automatic test_random_ops;
    int unsigned sel;
    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 2);
      press(sel != 1, sel != 0);
      vectors++; if (leds !== 4'(exp_op)) begin miscompares++; $display("FAIL rand_op[%0d] sel=%0d: got %0d expected %0d", k, sel, leds, exp_op); end
      vectors++; if (chk_if.data_o !== leds) begin miscompares++; $display("FAIL leds_eq_data[%0d]: got %0d expected %0d", k, leds, chk_if.data_o); end
    end
  endtask

  task automatic test_check(input int unsigned target, input int unsigned lat, input logic with_inc);
    int bcyc, ecnt;
    logic dok, tout, expv;
    chk_lat = lat;
    set_op(target);
    do_start(with_inc, bcyc, ecnt, dok, tout);
    expv = is_prime(exp_op);
    vectors++; if (tout) begin miscompares++; $display("FAIL busy_window op=%0d: got timeout expected completion", exp_op); end
    vectors++; if (ecnt != ((exp_op >= 2) ? 1 : 0)) begin miscompares++; $display("FAIL en_count op=%0d: got %0d expected %0d", exp_op, ecnt, (exp_op >= 2) ? 1 : 0); end
    vectors++; if (dok !== 1'b1) begin miscompares++; $display("FAIL data_stable op=%0d: got changed expected %0d", exp_op, exp_op); end
    vectors++; if (prime_led !== expv) begin miscompares++; $display("FAIL verdict op=%0d: got %b expected %b", exp_op, prime_led, expv); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL err_clear op=%0d: got %b expected 0", exp_op, err); end
    if (exp_op < 2) begin
      vectors++; if (bcyc != 1) begin miscompares++; $display("FAIL short_busy op=%0d: got %0d expected 1", exp_op, bcyc); end
    end
    exp_led = expv;
  endtask

  task automatic test_prime_ops;
    test_check(7, 3, 1'b0);
    test_check(9, 5, 1'b0);
    test_check(2, 0, 1'b0);
    for (int k = 0; k < 4; k++) test_check($urandom_range(2, 15), $urandom_range(0, 20), 1'b0);
    test_check(6, 2, 1'b1);   // start+inc together: request uses 7
    vectors++; if (leds !== 4'd7) begin miscompares++; $display("FAIL start_inc_op: got %0d expected 7", leds); end
    test_check(1, 2, 1'b0);   // short path after a verdict of 1
    test_check(0, 2, 1'b0);
  endtask

  task automatic test_busy_ignore;
    int n, en0;
    chk_lat = 30;
    set_op(11);
    en0 = en_total;
    @(negedge clk); start_raw = 1'b1;
    @(negedge clk); start_raw = 1'b0;
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    @(negedge clk); inc_raw = 1'b1; start_raw = 1'b1;
    @(negedge clk); inc_raw = 1'b0; start_raw = 1'b0;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_ignore_end: got %b expected 0", busy); end
    vectors++; if (leds !== 4'd11) begin miscompares++; $display("FAIL busy_ignore_op: got %0d expected 11", leds); end
    vectors++; if (en_total - en0 != 1) begin miscompares++; $display("FAIL busy_ignore_en: got %0d expected 1", en_total - en0); end
    vectors++; if (prime_led !== 1'b1) begin miscompares++; $display("FAIL busy_ignore_verdict: got %b expected 1", prime_led); end
    exp_led = 1'b1;
    press(1'b1, 1'b1);
    vectors++; if (leds !== 4'd11) begin miscompares++; $display("FAIL inc_dec_same: got %0d expected 11", leds); end
  endtask

  task automatic test_timeout;
    int bcyc, ecnt;
    logic dok, tout;
    test_check(13, 4, 1'b0);
    chk_stuck = 1'b1;
    set_op(5);
    do_start(1'b0, bcyc, ecnt, dok, tout);
    vectors++; if (tout) begin miscompares++; $display("FAIL timeout_window: got hang expected abort"); end
    vectors++; if (bcyc != 65) begin miscompares++; $display("FAIL timeout_busy: got %0d expected 65", bcyc); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %b expected 1", err); end
    vectors++; if (prime_led !== exp_led) begin miscompares++; $display("FAIL timeout_led: got %b expected %b", prime_led, exp_led); end
    chk_stuck = 1'b0;
    test_check(5, 3, 1'b0);   // also confirms err clears on the next start
  endtask

  task automatic test_reset_mid;
    int n;
    chk_lat = 40;
    set_op(13);
    @(negedge clk); start_raw = 1'b1;
    @(negedge clk); start_raw = 1'b0;
    n = 0;
    while (!(busy && !chk_if.valid_i) && n < 20) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b expected 1", busy); end
    rst_n = 1'b0;
    #1;
    vectors++; if (chk_if.en_o !== 1'b0) begin miscompares++; $display("FAIL mid_rst_en: got %b expected 0", chk_if.en_o); end
    vectors++; if (chk_if.data_o !== 4'd0) begin miscompares++; $display("FAIL mid_rst_data: got %0d expected 0", chk_if.data_o); end
    vectors++; if (leds !== 4'd0) begin miscompares++; $display("FAIL mid_rst_leds: got %0d expected 0", leds); end
    vectors++; if (prime_led !== 1'b0) begin miscompares++; $display("FAIL mid_rst_led: got %b expected 0", prime_led); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err: got %b expected 0", err); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_op = 0; exp_led = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_random_ops();
    test_prime_ops();
    test_busy_ignore();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
